// File: rtl/hmac512_pkg.sv
// Shared types for the HMAC-512 datapath.
//   sha_word_t   : 64-bit SHA-512 message word
//   sha_fifo_t   : message FIFO entry {data, mask}, mask[7] qualifies data[63:56]
//   pack_st_e    : message packer state
//   strb_legal   : 1 for the contiguous low-first strobe patterns the packer accepts
//   strb_count   : number of bytes carried by a legal strobe pattern
//   pack_merge   : appends k write bytes after n accumulated bytes
package hmac512_pkg;

   typedef logic [63:0] sha_word_t;

   typedef struct packed {
      sha_word_t  data;
      logic [7:0] mask;
   } sha_fifo_t;

   typedef enum logic [1:0] {
      StIdle,
      StAccept,
      StFlush,
      StWaitDrain
   } pack_st_e;

   function automatic logic strb_legal(input logic [3:0] strb);
      return (strb == 4'b0000) || (strb == 4'b0001) || (strb == 4'b0011) ||
             (strb == 4'b0111) || (strb == 4'b1111);
   endfunction

   function automatic logic [2:0] strb_count(input logic [3:0] strb);
      logic [2:0] cnt;
      case (strb)
         4'b0001: cnt = 3'd1;
         4'b0011: cnt = 3'd2;
         4'b0111: cnt = 3'd3;
         4'b1111: cnt = 3'd4;
         default: cnt = 3'd0;
      endcase
      return cnt;
   endfunction

   // Result holds 16 byte positions, position p in [127-8p -: 8]. The upper half is the word
   // being built; the lower half holds any overflow, already aligned to start at position 0.
   // Unused bytes of acc must be zero so the overflow half stays clean.
   function automatic logic [127:0] pack_merge(input logic [63:0] acc,
                                               input logic [2:0]  n,
                                               input logic [31:0] data,
                                               input logic [2:0]  k);
      logic [127:0] b;
      b = {acc, 64'h0};
      for (int i = 0; i < 4; i++) begin
         if (i < int'(k)) begin
            b[127 - 8 * (int'(n) + i) -: 8] = data[8 * i +: 8];
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/hmac512_msg_pack.sv
// Packs 32-bit CPU message writes (byte 0 first) into 64-bit big-endian FIFO words.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   sha_en                 engine enable, low returns the packer to idle
//   hash_start             pulse, begins a new message (discarding any in progress)
//   hash_process           pulse, marks message end; partial word flushed first
//   wr_valid_i/wr_data_i/wr_strb_i/wr_ready_o   CPU write channel
//   fifo_wvalid_o/fifo_wdata_o/fifo_wready_i    message FIFO push channel
//   fifo_depth_i           FIFO occupancy, used to know when the flush has landed
//   message_length_o       accepted message length in bits
//   hash_process_o         one-cycle pulse to the padder once the flush is complete
//   err_o                  one-cycle pulse for illegal strobes or writes outside a message
module hmac512_msg_pack
   import hmac512_pkg::*;
#(
   parameter int unsigned FifoDepthW = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  sha_en,
   input  logic                  hash_start,
   input  logic                  hash_process,
   input  logic                  wr_valid_i,
   input  logic [31:0]           wr_data_i,
   input  logic [3:0]            wr_strb_i,
   output logic                  wr_ready_o,
   output logic                  fifo_wvalid_o,
   output sha_fifo_t             fifo_wdata_o,
   input  logic                  fifo_wready_i,
   input  logic [FifoDepthW-1:0] fifo_depth_i,
   output logic [127:0]          message_length_o,
   output logic                  hash_process_o,
   output logic                  err_o
);

   pack_st_e     state_q, state_d;
   logic [63:0]  acc_q, acc_d;
   logic [2:0]   n_q, n_d;
   sha_fifo_t    out_q, out_d;
   logic         out_valid_q, out_valid_d;
   logic [127:0] len_q, len_d;
   logic         err_q, err_d;
   logic         hp_q, hp_d;
   logic         partial_q, partial_d;

   logic         wr_acc;
   logic         legal;
   logic [2:0]   k;
   logic [3:0]   sum;
   logic [127:0] merged;

   assign legal  = strb_legal(wr_strb_i);
   assign k      = strb_count(wr_strb_i);
   assign sum    = {1'b0, n_q} + {1'b0, k};
   assign merged = pack_merge(acc_q, n_q, wr_data_i, k);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      n_d         = n_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      len_d       = len_q;
      err_d       = 1'b0;
      hp_d        = 1'b0;
      partial_d   = partial_q;

      wr_ready_o = 1'b1;
      if (state_q == StAccept) begin
         wr_ready_o = !out_valid_q || fifo_wready_i;
      end
      wr_acc = wr_valid_i && wr_ready_o;

      // Handshake frees the output register; a reload below overrides this.
      if (out_valid_q && fifo_wready_i) begin
         out_valid_d = 1'b0;
         out_d       = '0;
      end

      case (state_q)
         StAccept: begin
            if (wr_acc) begin
               if (!legal) begin
                  err_d = 1'b1;
               end else begin
                  len_d = len_q + {122'd0, k, 3'b000};
                  if (sum[3]) begin
                     out_d       = '{data: merged[127:64], mask: 8'hFF};
                     out_valid_d = 1'b1;
                     acc_d       = merged[63:0];
                  end else begin
                     acc_d = merged[127:64];
                  end
                  n_d = sum[2:0];
               end
            end
            if (hash_process) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (n_q == 3'd0) begin
               partial_d = 1'b0;
               state_d   = StWaitDrain;
            end else if (!out_valid_q || fifo_wready_i) begin
               out_d       = '{data: acc_q, mask: ~(8'hFF >> n_q)};
               out_valid_d = 1'b1;
               acc_d       = '0;
               n_d         = 3'd0;
               partial_d   = 1'b1;
               state_d     = StWaitDrain;
            end
         end
         StWaitDrain: begin
            // The partial word must have reached the FIFO before the padder starts.
            if (!out_valid_q && (fifo_depth_i == FifoDepthW'(partial_q))) begin
               hp_d    = 1'b1;
               state_d = StIdle;
            end
         end
         default: ;
      endcase

      if (state_q != StAccept && wr_acc) begin
         err_d = 1'b1;
      end

      // Restart or disable wins over everything, including a same-cycle write.
      if (!sha_en || hash_start) begin
         acc_d       = '0;
         n_d         = 3'd0;
         out_d       = '0;
         out_valid_d = 1'b0;
         len_d       = '0;
         err_d       = 1'b0;
         hp_d        = 1'b0;
         partial_d   = 1'b0;
         state_d     = sha_en ? StAccept : StIdle;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         n_q         <= 3'd0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         len_q       <= '0;
         err_q       <= 1'b0;
         hp_q        <= 1'b0;
         partial_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         n_q         <= n_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         len_q       <= len_d;
         err_q       <= err_d;
         hp_q        <= hp_d;
         partial_q   <= partial_d;
      end
   end

   assign fifo_wvalid_o    = out_valid_q;
   assign fifo_wdata_o     = out_q;
   assign message_length_o = len_q;
   assign hash_process_o   = hp_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_hmac512_msg_pack.sv
// Bench for hmac512_msg_pack: directed scenarios followed by randomized messages, all checked
// against a byte-queue reference model.
module tb_hmac512_msg_pack;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sha_en = 1'b0;
   logic         hash_start = 1'b0;
   logic         hash_process = 1'b0;
   logic         wr_valid = 1'b0;
   logic [31:0]  wr_data = '0;
   logic [3:0]   wr_strb = '0;
   logic         wr_ready;
   logic         fifo_wvalid;
   logic [71:0]  fifo_wdata;
   logic         fifo_wready;
   logic [4:0]   fifo_depth = '0;
   logic [127:0] msg_len;
   logic         hp_out;
   logic         err_out;

   logic rand_mode = 1'b0;
   logic rdy_dir = 1'b1;
   logic rdy_rand = 1'b1;
   assign fifo_wready = rand_mode ? rdy_rand : rdy_dir;

   hmac512_msg_pack #(.FifoDepthW(5)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .sha_en           (sha_en),
      .hash_start       (hash_start),
      .hash_process     (hash_process),
      .wr_valid_i       (wr_valid),
      .wr_data_i        (wr_data),
      .wr_strb_i        (wr_strb),
      .wr_ready_o       (wr_ready),
      .fifo_wvalid_o    (fifo_wvalid),
      .fifo_wdata_o     (fifo_wdata),
      .fifo_wready_i    (fifo_wready),
      .fifo_depth_i     (fifo_depth),
      .message_length_o (msg_len),
      .hash_process_o   (hp_out),
      .err_o            (err_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rdy_rand = ($urandom_range(0, 9) < 7);
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: message as a byte queue; words emitted every 8 bytes.
   logic [7:0]   mbytes[$];
   logic [71:0]  exp_q[$];
   logic [127:0] exp_len = '0;
   logic         msg_open = 1'b0;
   logic         err_pend = 1'b0;
   logic         hp_owed = 1'b0;
   logic         hp_allowed = 1'b1;
   logic         last_partial = 1'b0;
   logic         prev_stall = 1'b0;
   logic [71:0]  prev_word = '0;

   function automatic int strb_k(input logic [3:0] s);
      case (s)
         4'b0000: return 0;
         4'b0001: return 1;
         4'b0011: return 2;
         4'b0111: return 3;
         4'b1111: return 4;
         default: return -1;
      endcase
   endfunction

   function automatic void emit(input int cnt);
      logic [63:0] w;
      logic [7:0]  m;
      w = '0;
      m = '0;
      for (int i = 0; i < cnt; i++) begin
         w[63 - 8 * i -: 8] = mbytes.pop_front();
         m[7 - i] = 1'b1;
      end
      exp_q.push_back({w, m});
   endfunction

   function automatic void model_clear();
      mbytes.delete();
      exp_q.delete();
      exp_len = '0;
      hp_owed = 1'b0;
      prev_stall = 1'b0;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         check_eq("err", err_out, err_pend);
         check_eq("len", msg_len, exp_len);
         if (hp_out) begin
            check_eq("hp_due", hp_owed && exp_q.size() == 0 && hp_allowed, 1);
            hp_owed = 1'b0;
         end
         if (prev_stall) begin
            check_eq("hold_valid", fifo_wvalid, 1);
            check_eq("hold_data", fifo_wdata, prev_word);
         end
         prev_stall = fifo_wvalid && !fifo_wready;
         prev_word  = fifo_wdata;
         if (sha_en && !hash_start) begin
            check_eq("ready", wr_ready, !msg_open || !fifo_wvalid || fifo_wready);
         end
         if (fifo_wvalid && fifo_wready) begin
            check_eq("push_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("push_word", fifo_wdata, exp_q.pop_front());
         end
         err_pend = 1'b0;
         if (!sha_en) begin
            model_clear();
            msg_open = 1'b0;
         end else if (hash_start) begin
            model_clear();
            msg_open = 1'b1;
         end else begin
            if (wr_valid && wr_ready) begin
               if (!msg_open || strb_k(wr_strb) < 0) begin
                  err_pend = 1'b1;
               end else begin
                  for (int i = 0; i < strb_k(wr_strb); i++) mbytes.push_back(wr_data[8 * i +: 8]);
                  exp_len += 128'(8 * strb_k(wr_strb));
                  while (mbytes.size() >= 8) emit(8);
               end
            end
            if (hash_process && msg_open) begin
               msg_open = 1'b0;
               last_partial = (mbytes.size() != 0);
               if (last_partial) emit(mbytes.size());
               hp_owed = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_finish();
      int g = 0;
      @(negedge clk);
      while (!wr_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) check_eq("wr_timeout", g, 0);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wr(input logic [31:0] d, input logic [3:0] s);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_strb  = s;
      wr_finish();
   endtask

   task automatic start();
      hash_start = 1'b1;
      tick();
      hash_start = 1'b0;
   endtask

   task automatic wait_hp();
      int g = 0;
      while (hp_owed && g < 300) begin
         tick();
         g++;
      end
      if (hp_owed) check_eq("hp_timeout", g, 0);
   endtask

   task automatic proc();
      hash_process = 1'b1;
      tick();
      hash_process = 1'b0;
      fifo_depth = last_partial ? 5'd1 : 5'd0;
      wait_hp();
      fifo_depth = 5'd0;
      tick();
   endtask

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_wvalid", fifo_wvalid, 0);
      check_eq("rst_wdata", fifo_wdata, 0);
      check_eq("rst_hp", hp_out, 0);
      check_eq("rst_err", err_out, 0);
      check_eq("rst_len", msg_len, 0);
      check_eq("rst_ready", wr_ready, 1);
      rst_n = 1'b1;
      sha_en = 1'b1;
      repeat (3) tick();

      // Two full writes make one word
      start();
      wr(32'h44332211, 4'hF);
      wr(32'h88776655, 4'hF);
      tick();
      check_eq("len64", msg_len, 64);
      proc();

      // Unaligned writes plus partial flush
      start();
      wr(32'h00002211, 4'h3);
      wr(32'h66554433, 4'hF);
      wr(32'hAA998877, 4'hF);
      tick();
      check_eq("len80", msg_len, 80);
      proc();

      // Flush completion gated on FIFO depth
      fifo_depth = 5'd2;
      hp_allowed = 1'b0;
      start();
      wr(32'h00CCBBAA, 4'h7);
      hash_process = 1'b1;
      tick();
      hash_process = 1'b0;
      repeat (10) tick();
      check_eq("hp_held", hp_owed, 1);
      fifo_depth = 5'd1;
      hp_allowed = 1'b1;
      wait_hp();
      fifo_depth = 5'd0;
      tick();

      // Back-pressure holds the output word and stalls writes
      rdy_dir = 1'b0;
      start();
      wr(32'h44332211, 4'hF);
      wr(32'h88776655, 4'hF);
      wr_valid = 1'b1;
      wr_data  = 32'hCCBBAA99;
      wr_strb  = 4'hF;
      repeat (3) tick();
      check_eq("stall_ready", wr_ready, 0);
      check_eq("stall_wvalid", fifo_wvalid, 1);
      check_eq("stall_data", fifo_wdata, {64'h1122334455667788, 8'hFF});
      rdy_dir = 1'b1;
      wr_finish();
      wr(32'h00FFEEDD, 4'hF);
      proc();

      // Illegal strobe, then write outside a message
      start();
      wr(32'h12345678, 4'b0101);
      check_eq("err_pulse", err_out, 1);
      wr(32'h00000011, 4'h1);
      wr(32'h00000000, 4'h0);
      proc();
      wr(32'hDEADBEEF, 4'hF);
      check_eq("err_idle", err_out, 1);
      tick();

      // Restart mid-message discards partial bytes
      start();
      wr(32'h00332211, 4'h7);
      start();
      check_eq("restart_len", msg_len, 0);
      wr(32'h44332211, 4'hF);
      wr(32'h88776655, 4'hF);
      proc();

      // Disable mid-message
      start();
      wr(32'h00332211, 4'h7);
      sha_en = 1'b0;
      tick();
      sha_en = 1'b1;
      tick();
      check_eq("dis_len", msg_len, 0);
      repeat (3) tick();

      // Randomized messages
      rand_mode = 1'b1;
      for (int m = 0; m < 40; m++) begin
         int nw;
         if ($urandom_range(0, 4) == 0) wr($urandom, 4'hF);
         start();
         nw = $urandom_range(0, 12);
         for (int w = 0; w < nw; w++) begin
            logic [3:0] s;
            if ($urandom_range(0, 9) == 0) begin
               s = 4'b0101;
               while (strb_k(s) < 0 && $urandom_range(0, 3) != 0) s = 4'($urandom);
            end else begin
               case ($urandom_range(0, 5))
                  0: s = 4'b0001;
                  1: s = 4'b0011;
                  2: s = 4'b0111;
                  3: s = 4'b0000;
                  default: s = 4'b1111;
               endcase
            end
            wr($urandom, s);
            if ($urandom_range(0, 3) == 0) tick();
         end
         if ($urandom_range(0, 2) == 0) begin
            wr_valid = 1'b1;
            wr_data  = $urandom;
            wr_strb  = 4'b0011;
            hash_process = 1'b1;
            tick();
            wr_valid = 1'b0;
            hash_process = 1'b0;
            fifo_depth = last_partial ? 5'd1 : 5'd0;
            wait_hp();
            fifo_depth = 5'd0;
            tick();
         end else begin
            proc();
         end
      end
      rand_mode = 1'b0;
      rdy_dir = 1'b1;
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
